// File: rtl/median_col_window.sv
// Vertical 3-pixel column generator for the median filter.
// Two line buffers turn a raster pixel stream into (top, mid, bot) columns.
module median_col_window #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [7:0]    col_top,
    output logic [7:0]    col_mid,
    output logic [7:0]    col_bot,
    output logic          col_valid,
    output logic [XW-1:0] col_x,
    output logic [YW-1:0] col_y,
    output logic          col_inner,
    output logic          col_eof
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [7:0] l1 [IMG_W];
    logic [7:0] l2 [IMG_W];

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          last_x;
    logic          last_y;
    logic [7:0]    rd1;
    logic [7:0]    rd2;
    logic [7:0]    mid_sel;
    logic [7:0]    top_sel;

    // sof forces the accepted pixel to (0,0) regardless of the counters
    always_comb begin
        px      = sof ? '0 : x;
        py      = sof ? '0 : y;
        last_x  = (px == X_LAST);
        last_y  = (py == Y_LAST);
        rd1     = l1[px];
        rd2     = l2[px];
        mid_sel = (py == '0) ? pix_in : rd1;
        top_sel = (py >= YW'(2)) ? rd2 : mid_sel;
    end

    // Line buffers carry no reset; y=0 rules hide stale contents
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            l2[px] <= rd1;
            l1[px] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (pix_valid) begin
            if (last_x) begin
                x <= '0;
                y <= last_y ? '0 : py + YW'(1);
            end else begin
                x <= px + XW'(1);
                y <= py;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_top   <= '0;
            col_mid   <= '0;
            col_bot   <= '0;
            col_valid <= 1'b0;
            col_x     <= '0;
            col_y     <= '0;
            col_inner <= 1'b0;
            col_eof   <= 1'b0;
        end else begin
            col_valid <= pix_valid;
            col_eof   <= pix_valid && last_x && last_y;
            if (pix_valid) begin
                col_top   <= top_sel;
                col_mid   <= mid_sel;
                col_bot   <= pix_in;
                col_x     <= px;
                col_y     <= py;
                col_inner <= (py >= YW'(2));
            end
        end
    end

endmodule
